fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-cycle RV32I core, directly upstream of the control unit. Owns the program counter, fetches each instruction from instruction memory over a req/ack handshake, and holds it stable for one execute window. During that window it presents `op`, `funct3` and `funct75` to the control unit. At the end of the window it consumes the control unit's `PCsrc` and the sign-extended immediate to select the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address; must be 4-byte aligned.
- `NOP`, 32'h0000_0013, instruction register value at reset (`addi x0,x0,0`).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory returns data this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ack`=1.
- `PCsrc`  in  1  branch taken, from the control unit.
- `ImmExt`  in  32  sign-extended branch offset.
- `stall`  in  1  extends the execute window.
- `instr`  out  32  held instruction.
- `op`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct75`  out  1  `instr[30]`.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc`+4.
- `instr_valid`  out  1  execute window active.
- `trap`  out  1  misaligned branch target; sticky.
- `trap_pc`  out  32  offending target address.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT. Reset state is IDLE.
- IDLE → FETCH unconditionally on the next edge.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`. On an edge with `imem_ack`=1, `instr` ← `imem_rdata` and the FSM moves to EXEC. Otherwise it stays in FETCH, with no timeout.
- EXEC: `instr_valid`=1 and `imem_req`=0.
  - `stall`=1: stay in EXEC; `instr` and `pc` are held.
  - `stall`=0: compute target = `pc`+`ImmExt` and next = `PCsrc` ? target : `pc_plus4`.
  - If `PCsrc`=1 and target[1:0]≠0: enter HALT, set `trap`=1, latch `trap_pc`=target; `pc` is unchanged.
  - Otherwise: `pc` ← next and the FSM moves to FETCH.
- HALT: `imem_req`=0 and `instr_valid`=0. Only `rst_n` exits HALT.
- `imem_ack` is ignored outside FETCH.
- `PCsrc` and `ImmExt` are ignored outside EXEC, and also ignored while `stall`=1.
- Arithmetic is 32-bit modulo 2^32, with no overflow detection. Example: `pc`=32'hFFFF_FFFC gives `pc_plus4`=0.
- `ImmExt` is used as provided; this block does not shift it.
- `op`, `funct3`, `funct75` and `pc_plus4` are combinational from the registers.

## Timing
- Reset values (async, immediate on `rst_n` low):
  - `pc`=`RESET_PC`, `instr`=`NOP`, `trap_pc`=0.
  - `imem_req`=0, `instr_valid`=0, `trap`=0.
- Reset in any state aborts it. An `imem_ack` that arrives after reset release for a pre-reset request lands in IDLE and is ignored.
- Fetch latency: `imem_req` rises 1 cycle after reset release. With a zero-wait memory (ack in the same cycle as req), each instruction occupies 2 cycles (FETCH+EXEC). Each memory wait cycle adds 1 cycle; each `stall` cycle adds 1 cycle.
- `instr_valid` rises on the edge that captures `imem_ack`. It falls on the edge that leaves EXEC.
- `PCsrc` and `ImmExt` are sampled on the edge that leaves EXEC.
- `imem_addr` changes only on the edge that enters FETCH.

## Structure
- Shared package `riscv_pkg`: XLEN=32, NOP encoding, RESET_PC default, opcode constants (load, store, R-type, I-type, branch), and the fetch FSM state enum.
- One natural sub-module: `fetch_pc_next`, combinational. Inputs: `pc`, `ImmExt`, `PCsrc`. Outputs: `pc_plus4`, target, next, misaligned flag.

## Test plan
- Reset release, memory acks in the same cycle, `stall`=0, `PCsrc`=0 → `imem_addr` sequence 0, 4, 8, 12, one instruction every 2 cycles; `instr_valid` toggles 0,1,0,1.
- In EXEC with `pc`=0x20, `PCsrc`=1, `ImmExt`=32'hFFFF_FFF0 → next `imem_addr`=0x10. Same case with `PCsrc`=0 → 0x24.
- Memory ack delayed 3 cycles → `imem_req` stays high with `imem_addr` stable for 4 cycles; `instr` updates only on the ack edge.
- `stall`=1 for 5 EXEC cycles with `PCsrc` toggling → `pc` and `instr` unchanged; only the `PCsrc` value on the releasing cycle takes effect.
- `pc`=0x40, `PCsrc`=1, `ImmExt`=6 → HALT, `trap`=1, `trap_pc`=0x46. No further `imem_req` until `rst_n` is asserted; after reset, `trap`=0 and fetch restarts at `RESET_PC`.
- `rst_n` asserted mid-FETCH with an ack pending one cycle after release → ack ignored, first fetch is at `RESET_PC`. Separately, `pc`=32'hFFFF_FFFC with `PCsrc`=0 → next fetch at 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I core: data width, reset defaults,
// opcode constants and the fetch-stage FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013; // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC arithmetic for the fetch stage. Purely combinational.
// All sums wrap modulo 2^32. The immediate is used unshifted.
module fetch_pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic            pc_src_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] next_o,
  output logic            misaligned_o
);

  assign pc_plus4_o   = pc_i + 32'd4;
  assign target_o     = pc_i + imm_ext_i;
  assign next_o       = pc_src_i ? target_o : pc_plus4_o;
  // pc itself is always word aligned, so only a taken branch can misalign.
  assign misaligned_o = pc_src_i && (target_o[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack port,
// holds the instruction for one execute window, then selects the next PC.
//
// Memory handshake: imem_req is high only in FETCH, and imem_req and
// imem_addr stay constant until a rising edge on which imem_ack=1; that
// edge captures imem_rdata. imem_ack seen in any other state is ignored.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              PCsrc,
  input  logic [XLEN-1:0]   ImmExt,
  input  logic              stall,
  output logic [XLEN-1:0]   instr,
  output logic [6:0]        op,
  output logic [2:0]        funct3,
  output logic              funct75,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              instr_valid,
  output logic              trap,
  output logic [XLEN-1:0]   trap_pc,
  output fetch_state_e      dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  fetch_pc_next u_pc_next (
    .pc_i         (pc_q),
    .imm_ext_i    (ImmExt),
    .pc_src_i     (PCsrc),
    .pc_plus4_o   (pc_plus4),
    .target_o     (target),
    .next_o       (next_pc),
    .misaligned_o (misaligned)
  );

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  // Next-state logic: fetch, execute window, and the sticky trap halt.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // PCsrc/ImmExt only matter on the cycle that ends the window.
        if (!stall) begin
          if (misaligned) begin
            state_d   = ST_HALT;
            trap_d    = 1'b1;
            trap_pc_d = target;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct75     = instr_q[30];
  assign pc          = pc_q;
  assign trap        = trap_q;
  assign trap_pc     = trap_pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple instruction memory model.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         PCsrc;
  logic [31:0]  ImmExt;
  logic         stall;
  logic [31:0]  instr;
  logic [6:0]   op;
  logic [2:0]   funct3;
  logic         funct75;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         instr_valid;
  logic         trap;
  logic [31:0]  trap_pc;
  fetch_state_e dbg_state;

  int n_total;
  int n_bad;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PCsrc       (PCsrc),
    .ImmExt      (ImmExt),
    .stall       (stall),
    .instr       (instr),
    .op          (op),
    .funct3      (funct3),
    .funct75     (funct75),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .trap        (trap),
    .trap_pc     (trap_pc),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents: distinct word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h4000_5033;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // hold reset two edges, release at a falling edge; DUT left in IDLE
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; PCsrc = 1'b0; ImmExt = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // reset, then branch to addr so the DUT sits in EXEC with pc=addr
  task automatic run_to_exec(input logic [31:0] addr);
    do_reset();
    imem_ack = 1'b1;
    step();           // FETCH @0
    step();           // EXEC  @0
    if (addr != 32'h0) begin
      PCsrc = 1'b1; ImmExt = addr;
      step();         // FETCH @addr
      PCsrc = 1'b0; ImmExt = '0;
      step();         // EXEC  @addr
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    rst_n = 1'b1; imem_ack = 1'b0; stall = 1'b0; PCsrc = 1'b0; ImmExt = '0;

    // ---- reset values ----
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_trap_pc", trap_pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_trap", 32'(trap), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // ---- zero-wait sequential fetch ----
    do_reset();
    imem_ack = 1'b1;
    check("idle_req", 32'(imem_req), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_fetch_req", 32'(imem_req), 32'h1);
      check("seq_fetch_addr", imem_addr, 32'(k * 4));
      check("seq_fetch_valid", 32'(instr_valid), 32'h0);
      step();
      check("seq_exec_valid", 32'(instr_valid), 32'h1);
      check("seq_exec_req", 32'(imem_req), 32'h0);
      check("seq_exec_instr", instr, mem_word(32'(k * 4)));
      check("seq_pc_plus4", pc_plus4, 32'(k * 4 + 4));
      if (k == 0) begin
        check("seq_op", 32'(op), 32'h33);
        check("seq_funct3", 32'(funct3), 32'h5);
        check("seq_funct75", 32'(funct75), 32'h1);
      end
    end

    // ---- taken backward branch and not-taken ----
    run_to_exec(32'h20);
    check("br_pc", pc, 32'h20);
    PCsrc = 1'b1; ImmExt = 32'hFFFF_FFF0;
    step();
    check("br_taken_addr", imem_addr, 32'h10);
    check("br_taken_req", 32'(imem_req), 32'h1);
    run_to_exec(32'h20);
    PCsrc = 1'b0; ImmExt = 32'hFFFF_FFF0;
    step();
    check("br_not_taken_addr", imem_addr, 32'h24);

    // ---- memory wait states ----
    run_to_exec(32'h0);
    imem_ack = 1'b0;
    step();                      // FETCH @4, no ack
    for (int i = 0; i < 3; i++) begin
      check("wait_req", 32'(imem_req), 32'h1);
      check("wait_addr", imem_addr, 32'h4);
      check("wait_instr", instr, mem_word(32'h0));
      check("wait_valid", 32'(instr_valid), 32'h0);
      step();
    end
    check("wait_req4", 32'(imem_req), 32'h1);
    check("wait_addr4", imem_addr, 32'h4);
    imem_ack = 1'b1;
    step();
    check("wait_ack_instr", instr, mem_word(32'h4));
    check("wait_ack_valid", 32'(instr_valid), 32'h1);

    // ---- stall with toggling PCsrc ----
    run_to_exec(32'h20);
    stall = 1'b1; ImmExt = 32'h100;
    for (int i = 0; i < 5; i++) begin
      PCsrc = (i % 2 == 0);
      step();
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_pc", pc, 32'h20);
      check("stall_instr", instr, mem_word(32'h20));
    end
    stall = 1'b0; PCsrc = 1'b0;
    step();
    check("stall_release_addr", imem_addr, 32'h24);
    check("stall_release_req", 32'(imem_req), 32'h1);

    // ---- misaligned target trap ----
    run_to_exec(32'h40);
    PCsrc = 1'b1; ImmExt = 32'h6;
    step();
    PCsrc = 1'b0; ImmExt = '0;
    check("trap_flag", 32'(trap), 32'h1);
    check("trap_pc", trap_pc, 32'h46);
    check("trap_pc_held", pc, 32'h40);
    check("trap_valid", 32'(instr_valid), 32'h0);
    check("trap_state", 32'(dbg_state), 32'(ST_HALT));
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_no_req", 32'(imem_req), 32'h0);
      check("halt_trap_sticky", 32'(trap), 32'h1);
    end
    rst_n = 1'b0;
    #1;
    check("trap_clr_async", 32'(trap), 32'h0);
    check("trap_clr_pc", pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("post_trap_req", 32'(imem_req), 32'h1);
    check("post_trap_addr", imem_addr, 32'h0);

    // ---- reset mid-FETCH with a stale ack ----
    run_to_exec(32'h0);
    imem_ack = 1'b0;
    step();                      // FETCH @4
    check("abort_pre_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; imem_ack = 1'b1; // ack lands while in IDLE
    step();
    check("abort_req", 32'(imem_req), 32'h1);
    check("abort_addr", imem_addr, 32'h0);
    check("abort_instr", instr, NOP_INSTR);
    check("abort_valid", 32'(instr_valid), 32'h0);
    step();
    check("abort_exec_instr", instr, mem_word(32'h0));

    // ---- PC wraparound ----
    run_to_exec(32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    PCsrc = 1'b0;
    step();
    check("wrap_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // guard against an unexpectedly long run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
